cr_crc_frame_chk: RTL and testbench
===================================

Name: cr_crc_frame_chk

Overview:
- Frame-level sequencer and checker in front of the 64-bit CRC-32 engine (one 8-byte beat per update, thermometer valid-byte mask).
- Accepts a beat stream with start/end-of-frame markers and drives the engine's init, data-valid and valid-byte controls.
- After the last beat, captures the engine's CRC and compares it to the expected CRC delivered with the EOF beat.
- Emits one status record per frame through a valid/ready handshake.

Parameters:
- INIT_VALUE, 32'hFFFF_FFFF, value loaded into the engine at the start of each frame.
- BEAT_CNT_W, 16, width of the per-frame beat counter and the drop counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  64  beat payload
- in_sof  in  1  first beat of frame
- in_eof  in  1  last beat of frame
- in_vbytes  in  8  valid-byte thermometer mask (8'h01..8'hFF); must be 8'hFF on non-EOF beats
- in_exp_crc  in  32  expected CRC; sampled on the accepted EOF beat only
- crc_init  out  1  engine init strobe
- crc_init_value  out  32  constant INIT_VALUE
- crc_data  out  64  registered beat data to engine
- crc_data_valid  out  1  engine update strobe
- crc_vbytes  out  8  registered mask to engine
- crc_enable  out  1  constant 1 after reset
- crc_in  in  32  engine CRC output; reflects updates one cycle after the strobe
- stat_valid  out  1  status record available
- stat_ready  in  1  status record consumed when stat_valid & stat_ready
- stat_crc  out  32  CRC captured from crc_in
- stat_match  out  1  stat_crc == expected CRC, and no error
- stat_err  out  1  protocol error in frame
- stat_beats  out  BEAT_CNT_W  beats accepted in frame
- drop_cnt  out  BEAT_CNT_W  saturating count of beats dropped outside frames

Behaviour:
- Reset: all outputs 0 except crc_init_value = INIT_VALUE. crc_enable = 0 during reset, 1 afterwards. State = IDLE. Counters and flags are cleared.
- Engine drive registers (crc_data, crc_vbytes, crc_data_valid, crc_init): registered outputs, one cycle after the causing event.
- States: IDLE, INIT, DATA, FINAL, REPORT.
- IDLE:
  - in_ready = 1 only for non-SOF beats. Such beats are dropped and drop_cnt increments, saturating at all-ones.
  - When in_valid & in_sof: in_ready = 0 (the SOF beat is held, not consumed). Assert crc_init next cycle, clear beat count and error flag, go to INIT.
- INIT: one bubble cycle so the init strobe lands before any data strobe (the engine gives init priority over data). in_ready = 0. Go to DATA.
- DATA:
  - in_ready = 1, except when in_valid & in_sof and the beat count is nonzero.
  - Each accepted beat: crc_data_valid = 1 next cycle with crc_data = in_data and crc_vbytes = in_vbytes. Beat count increments, saturating; reaching saturation sets the error flag.
  - Set the error flag on:
    - a non-EOF beat with in_vbytes != 8'hFF;
    - an EOF beat with in_vbytes not a legal thermometer value (01,03,07,0F,1F,3F,7F,FF). The beat is still forwarded; the engine treats it as zero bits.
  - The SOF beat itself (count == 0) is accepted normally. A beat with both SOF and EOF is a one-beat frame.
  - Accepted EOF beat: latch in_exp_crc, go to FINAL.
  - SOF while count != 0 (abort): do not consume the beat, set the error flag, go to FINAL. The held SOF beat starts the next frame from IDLE.
- FINAL:
  - in_ready = 0.
  - The last crc_data_valid is asserted this cycle, so the engine result appears the following cycle. FINAL therefore lasts 2 cycles; capture crc_in on the second cycle.
  - stat_match = ~err & (crc_in == exp_crc). For an aborted frame, exp_crc = 0 and match = 0.
  - Go to REPORT with stat_valid = 1.
- REPORT:
  - in_ready = 0. Stat outputs are held stable while stat_valid & ~stat_ready.
  - On handshake: stat_valid = 0 and go to IDLE, which may start the next frame in the same cycle.
- Latency: accepted EOF to stat_valid = 3 cycles. Minimum frame overhead = 1 INIT + 2 FINAL + 1 REPORT cycles.
- Reset mid-frame: immediate return to IDLE. The frame is lost, no status is emitted, and the engine sees no further strobes.

Test Plan:
- 1-beat frame, data 64'h0, vbytes 8'hFF, exp_crc = golden CRC of 8 zero bytes from INIT_VALUE -> crc_init pulse, crc_data_valid 2 cycles later, stat_valid 3 cycles after EOF, stat_match=1, stat_err=0, stat_beats=1.
- 3-beat frame, last vbytes 8'h07, wrong exp_crc (golden ^ 1) -> stat_match=0, stat_err=0, stat_beats=3, stat_crc = golden.
- 2 beats without SOF in IDLE -> both accepted and dropped, drop_cnt=2, no crc strobes, no status.
- SOF, 2 beats, then a new SOF before EOF -> status with stat_err=1, stat_match=0, stat_beats=2; second frame then runs normally with its own crc_init.
- Non-EOF beat with vbytes 8'h0F, or EOF with 8'h05 -> stat_err=1, stat_match=0 even when the CRC equals exp_crc.
- stat_ready held low 10 cycles -> stat fields stable, in_ready=0 throughout; next frame starts the cycle after the handshake. Assert rst_n low mid-DATA -> all outputs return to reset values.

Source files
------------

// File: rtl/cr_crc_frame_chk.sv
// Frame sequencer/checker in front of a 64-bit CRC-32 engine.
// Drives engine strobes per beat and reports one status per frame.
module cr_crc_frame_chk #(
  parameter logic [31:0] INIT_VALUE = 32'hFFFF_FFFF,
  parameter int          BEAT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_data,
  input  logic                  in_sof,
  input  logic                  in_eof,
  input  logic [7:0]            in_vbytes,
  input  logic [31:0]           in_exp_crc,
  output logic                  crc_init,
  output logic [31:0]           crc_init_value,
  output logic [63:0]           crc_data,
  output logic                  crc_data_valid,
  output logic [7:0]            crc_vbytes,
  output logic                  crc_enable,
  input  logic [31:0]           crc_in,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [31:0]           stat_crc,
  output logic                  stat_match,
  output logic                  stat_err,
  output logic [BEAT_CNT_W-1:0] stat_beats,
  output logic [BEAT_CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DATA,
    S_FINAL,
    S_REPORT
  } state_t;

  localparam logic [BEAT_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [BEAT_CNT_W-1:0] CNT_ONE =
    {{(BEAT_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state;
  logic                    fin_2nd;
  logic [BEAT_CNT_W-1:0]   beat_cnt;
  logic                    err;
  logic [31:0]             exp_crc;
  logic                    abort;
  logic                    vb_therm;
  logic                    accept;

  assign crc_init_value = INIT_VALUE;

  assign abort = in_valid & in_sof & (|beat_cnt);
  assign vb_therm = (|in_vbytes) &
    ((in_vbytes & (in_vbytes + 8'd1)) == 8'd0);
  assign accept = in_valid & in_ready;

  // crc_enable doubles as "out of reset" so in_ready stays low in reset
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      S_IDLE:  in_ready = crc_enable & ~(in_valid & in_sof);
      S_DATA:  in_ready = ~abort;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      fin_2nd        <= 1'b0;
      beat_cnt       <= '0;
      err            <= 1'b0;
      exp_crc        <= '0;
      crc_init       <= 1'b0;
      crc_data       <= '0;
      crc_data_valid <= 1'b0;
      crc_vbytes     <= '0;
      crc_enable     <= 1'b0;
      stat_valid     <= 1'b0;
      stat_crc       <= '0;
      stat_match     <= 1'b0;
      stat_err       <= 1'b0;
      stat_beats     <= '0;
      drop_cnt       <= '0;
    end else begin
      crc_enable     <= 1'b1;
      crc_init       <= 1'b0;
      crc_data_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_sof) begin
            crc_init <= 1'b1;
            beat_cnt <= '0;
            err      <= 1'b0;
            exp_crc  <= '0;
            fin_2nd  <= 1'b0;
            state    <= S_INIT;
          end else if (accept && drop_cnt != CNT_MAX) begin
            drop_cnt <= drop_cnt + CNT_ONE;
          end
        end
        S_INIT: state <= S_DATA;
        S_DATA: begin
          if (abort) begin
            err     <= 1'b1;
            exp_crc <= '0;
            state   <= S_FINAL;
          end else if (in_valid) begin
            crc_data_valid <= 1'b1;
            crc_data       <= in_data;
            crc_vbytes     <= in_vbytes;
            if (beat_cnt != CNT_MAX)
              beat_cnt <= beat_cnt + CNT_ONE;
            if (beat_cnt >= CNT_MAX - CNT_ONE)
              err <= 1'b1;
            if (!in_eof && (in_vbytes != 8'hFF))
              err <= 1'b1;
            if (in_eof && !vb_therm)
              err <= 1'b1;
            if (in_eof) begin
              exp_crc <= in_exp_crc;
              state   <= S_FINAL;
            end
          end
        end
        // engine result lags the last strobe by a cycle
        S_FINAL: begin
          if (!fin_2nd) begin
            fin_2nd <= 1'b1;
          end else begin
            stat_crc   <= crc_in;
            stat_match <= ~err & (crc_in == exp_crc);
            stat_err   <= err;
            stat_beats <= beat_cnt;
            stat_valid <= 1'b1;
            state      <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (stat_ready) begin
            stat_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_crc_frame_chk.sv
// Directed bench for cr_crc_frame_chk with a behavioural
// reflected CRC-32 engine attached to the engine ports.
module tb_cr_crc_frame_chk;

  localparam logic [31:0] IV = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [7:0]  in_vbytes = 8'hFF;
  logic [31:0] in_exp_crc = '0;
  logic        crc_init;
  logic [31:0] crc_init_value;
  logic [63:0] crc_data;
  logic        crc_data_valid;
  logic [7:0]  crc_vbytes;
  logic        crc_enable;
  logic [31:0] crc_in;
  logic        stat_valid;
  logic        stat_ready = 1'b0;
  logic [31:0] stat_crc;
  logic        stat_match;
  logic        stat_err;
  logic [15:0] stat_beats;
  logic [15:0] drop_cnt;

  int n_asrt = 0;
  int n_fail = 0;
  int n_init = 0;
  int n_dv = 0;

  always #5 clk = ~clk;

  cr_crc_frame_chk #(.INIT_VALUE(IV), .BEAT_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .in_eof(in_eof),
    .in_vbytes(in_vbytes), .in_exp_crc(in_exp_crc),
    .crc_init(crc_init), .crc_init_value(crc_init_value),
    .crc_data(crc_data), .crc_data_valid(crc_data_valid),
    .crc_vbytes(crc_vbytes), .crc_enable(crc_enable),
    .crc_in(crc_in),
    .stat_valid(stat_valid), .stat_ready(stat_ready),
    .stat_crc(stat_crc), .stat_match(stat_match),
    .stat_err(stat_err), .stat_beats(stat_beats),
    .drop_cnt(drop_cnt)
  );

  function automatic logic [31:0] crc64(
    input logic [31:0] c,
    input logic [63:0] d,
    input logic [7:0]  v
  );
    logic [31:0] r;
    r = c;
    if (v == 8'd0 || (v & (v + 8'd1)) != 8'd0) return c;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        r = r ^ {24'd0, d[8*i +: 8]};
        for (int b = 0; b < 8; b++)
          r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
    end
    return r;
  endfunction

  // engine model: init wins over data, result visible next cycle
  logic [31:0] eng;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng <= '0;
    else if (crc_init) eng <= crc_init_value;
    else if (crc_data_valid) eng <= crc64(eng, crc_data, crc_vbytes);
  end
  assign crc_in = eng;

  always @(negedge clk) begin
    if (crc_init) n_init++;
    if (crc_data_valid) n_dv++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    n_asrt++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic send_beat(input logic [63:0] d,
                           input logic s, input logic e,
                           input logic [7:0] v,
                           input logic [31:0] x);
    int k;
    in_valid = 1'b1; in_data = d; in_sof = s; in_eof = e;
    in_vbytes = v; in_exp_crc = x;
    k = 0;
    #1;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic wait_stat(output int lat);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!stat_valid && lat < 20);
    chk("stat_timeout", {63'd0, stat_valid}, 64'd1);
  endtask

  task automatic ack();
    stat_ready = 1'b1;
    @(posedge clk); #1;
    stat_ready = 1'b0;
  endtask

  logic [31:0] g0, g3, ge;
  logic [63:0] d0, d1, d2;
  int lat, i0, dv0, k;

  initial begin
    g0 = crc64(IV, 64'd0, 8'hFF);
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_crc_enable", {63'd0, crc_enable}, 64'd0);
    chk("rst_init_value", {32'd0, crc_init_value}, {32'd0, IV});
    chk("rst_stat_valid", {63'd0, stat_valid}, 64'd0);
    chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    rst_n = 1'b1;

    // one-beat frame, exact strobe timing
    @(posedge clk); #1;
    chk("en_after_rst", {63'd0, crc_enable}, 64'd1);
    in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1;
    in_data = 64'd0; in_vbytes = 8'hFF; in_exp_crc = g0;
    @(negedge clk);
    chk("t1_idle_sof_hold", {63'd0, in_ready}, 64'd0);
    chk("t1_no_init_yet", {63'd0, crc_init}, 64'd0);
    @(negedge clk);
    chk("t1_init_pulse", {63'd0, crc_init}, 64'd1);
    chk("t1_init_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("t1_data_ready", {63'd0, in_ready}, 64'd1);
    chk("t1_init_off", {63'd0, crc_init}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    @(negedge clk);
    chk("t1_dv", {63'd0, crc_data_valid}, 64'd1);
    chk("t1_vbytes", {56'd0, crc_vbytes}, 64'hFF);
    @(negedge clk);
    chk("t1_stat_early", {63'd0, stat_valid}, 64'd0);
    @(negedge clk);
    chk("t1_stat_lat3", {63'd0, stat_valid}, 64'd1);
    chk("t1_crc", {32'd0, stat_crc}, {32'd0, g0});
    chk("t1_match", {63'd0, stat_match}, 64'd1);
    chk("t1_err", {63'd0, stat_err}, 64'd0);
    chk("t1_beats", {48'd0, stat_beats}, 64'd1);
    ack();
    @(negedge clk);
    chk("t1_stat_clear", {63'd0, stat_valid}, 64'd0);

    // three-beat frame, short tail, wrong expected CRC
    d0 = 64'h1122_3344_5566_7788;
    d1 = 64'hDEAD_BEEF_CAFE_F00D;
    d2 = 64'h0123_4567_89AB_CDEF;
    g3 = crc64(crc64(crc64(IV, d0, 8'hFF), d1, 8'hFF), d2, 8'h07);
    @(posedge clk); #1;
    send_beat(d0, 1'b1, 1'b0, 8'hFF, 32'd0);
    send_beat(d1, 1'b0, 1'b0, 8'hFF, 32'd0);
    send_beat(d2, 1'b0, 1'b1, 8'h07, g3 ^ 32'd1);
    wait_stat(lat);
    chk("t2_lat", lat, 64'd3);
    chk("t2_crc", {32'd0, stat_crc}, {32'd0, g3});
    chk("t2_match", {63'd0, stat_match}, 64'd0);
    chk("t2_err", {63'd0, stat_err}, 64'd0);
    chk("t2_beats", {48'd0, stat_beats}, 64'd3);
    ack();

    // beats without SOF in IDLE are dropped
    i0 = n_init; dv0 = n_dv;
    send_beat(64'hAA, 1'b0, 1'b0, 8'hFF, 32'd0);
    send_beat(64'hBB, 1'b0, 1'b1, 8'hFF, 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_drop_cnt", {48'd0, drop_cnt}, 64'd2);
    chk("t3_no_init", n_init - i0, 64'd0);
    chk("t3_no_dv", n_dv - dv0, 64'd0);
    chk("t3_no_stat", {63'd0, stat_valid}, 64'd0);

    // abort by a new SOF, then the held SOF runs its own frame
    @(posedge clk); #1;
    send_beat(d0, 1'b1, 1'b0, 8'hFF, 32'd0);
    send_beat(d1, 1'b0, 1'b0, 8'hFF, 32'd0);
    i0 = n_init;
    in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b1;
    in_data = 64'd0; in_vbytes = 8'hFF; in_exp_crc = g0;
    wait_stat(lat);
    chk("t4_abort_err", {63'd0, stat_err}, 64'd1);
    chk("t4_abort_match", {63'd0, stat_match}, 64'd0);
    chk("t4_abort_beats", {48'd0, stat_beats}, 64'd2);
    chk("t4_hold_ready", {63'd0, in_ready}, 64'd0);
    ack();
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("t4_restart_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    wait_stat(lat);
    chk("t4_f2_lat", lat, 64'd3);
    chk("t4_f2_match", {63'd0, stat_match}, 64'd1);
    chk("t4_f2_err", {63'd0, stat_err}, 64'd0);
    chk("t4_f2_beats", {48'd0, stat_beats}, 64'd1);
    chk("t4_f2_crc", {32'd0, stat_crc}, {32'd0, g0});
    chk("t4_f2_init", n_init - i0, 64'd1);
    ack();

    // non-EOF beat with partial mask: error despite good CRC
    ge = crc64(crc64(IV, d0, 8'h0F), d1, 8'hFF);
    send_beat(d0, 1'b1, 1'b0, 8'h0F, 32'd0);
    send_beat(d1, 1'b0, 1'b1, 8'hFF, ge);
    wait_stat(lat);
    chk("t5a_crc", {32'd0, stat_crc}, {32'd0, ge});
    chk("t5a_err", {63'd0, stat_err}, 64'd1);
    chk("t5a_match", {63'd0, stat_match}, 64'd0);
    ack();

    // EOF with non-thermometer mask: engine sees no bytes
    send_beat(d2, 1'b1, 1'b1, 8'h05, IV);
    wait_stat(lat);
    chk("t5b_crc", {32'd0, stat_crc}, {32'd0, IV});
    chk("t5b_err", {63'd0, stat_err}, 64'd1);
    chk("t5b_match", {63'd0, stat_match}, 64'd0);
    ack();

    // status back-pressure with the next SOF waiting
    send_beat(64'd0, 1'b1, 1'b1, 8'hFF, g0);
    wait_stat(lat);
    in_valid = 1'b1; in_sof = 1'b1; in_eof = 1'b0;
    in_data = d1; in_vbytes = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t6_stall_valid", {63'd0, stat_valid}, 64'd1);
      chk("t6_stall_crc", {32'd0, stat_crc}, {32'd0, g0});
      chk("t6_stall_ready", {63'd0, in_ready}, 64'd0);
    end
    i0 = n_init;
    ack();
    @(negedge clk);
    chk("t6_post_valid", {63'd0, stat_valid}, 64'd0);
    chk("t6_post_noinit", {63'd0, crc_init}, 64'd0);
    @(negedge clk);
    chk("t6_next_init", {63'd0, crc_init}, 64'd1);
    k = 0;
    #1;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("t6_data_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    chk("t6_dv", {63'd0, crc_data_valid}, 64'd1);
    chk("t6_data", crc_data, d1);

    // reset in the middle of DATA
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_ready", {63'd0, in_ready}, 64'd0);
    chk("t7_rst_en", {63'd0, crc_enable}, 64'd0);
    chk("t7_rst_dv", {63'd0, crc_data_valid}, 64'd0);
    chk("t7_rst_data", crc_data, 64'd0);
    chk("t7_rst_crc", {32'd0, stat_crc}, 64'd0);
    chk("t7_rst_drop", {48'd0, drop_cnt}, 64'd0);
    chk("t7_rst_iv", {32'd0, crc_init_value}, {32'd0, IV});
    @(negedge clk);
    rst_n = 1'b1;
    i0 = n_init; dv0 = n_dv;
    repeat (6) @(negedge clk);
    chk("t7_no_init", n_init - i0, 64'd0);
    chk("t7_no_dv", n_dv - dv0, 64'd0);
    chk("t7_no_stat", {63'd0, stat_valid}, 64'd0);
    chk("t7_en_back", {63'd0, crc_enable}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
